// File: rtl/mem_stage_lsu.sv
// Memory stage: drives data-cache requests, aligns store lanes, extends load data
// and registers the retiring result into the MEM/WB register.
module mem_stage_lsu #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SRC_WIDTH      = 2,
    parameter int MEM_CTRL_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_m,
    input  logic [DATA_WIDTH-1:0]     PCPlus4_m,
    input  logic [DATA_WIDTH-1:0]     ALUResult_m,
    input  logic [DATA_WIDTH-1:0]     WriteData_m,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_m,
    input  logic                      RegWrite_m,
    input  logic [SRC_WIDTH-1:0]      ResultSrc_m,
    input  logic                      MemWrite_m,
    input  logic [MEM_CTRL_WIDTH-1:0] MemCtrl_m,
    output logic                      dc_req,
    output logic                      dc_we,
    output logic [DATA_WIDTH-1:0]     dc_addr,
    output logic [DATA_WIDTH-1:0]     dc_wdata,
    output logic [3:0]                dc_wstrb,
    input  logic                      dc_ready,
    input  logic                      dc_rvalid,
    input  logic [DATA_WIDTH-1:0]     dc_rdata,
    output logic                      stall_m,
    output logic                      valid_w,
    output logic [DATA_WIDTH-1:0]     Result_w,
    output logic [REG_ADDR_WIDTH-1:0] Rd_w,
    output logic                      RegWrite_w,
    output logic                      misalign_w
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t                    state_q, state_d;
    logic                      valid_q, regWrite_q, misalign_q;
    logic [DATA_WIDTH-1:0]     result_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q;

    logic                  isLoad, isStore, memOp;
    logic                  ctrlLegal, sizeMis, misalign, alignedMem, retire;
    logic [1:0]            off;
    logic [7:0]            loadByte;
    logic [15:0]           loadHalf;
    logic [DATA_WIDTH-1:0] loadData, result;

    assign off        = ALUResult_m[1:0];
    assign isLoad     = valid_m & (ResultSrc_m == SRC_WIDTH'(1)) & ~MemWrite_m;
    assign isStore    = valid_m & MemWrite_m;
    assign memOp      = isLoad | isStore;

    always_comb begin
        ctrlLegal = 1'b1;
        sizeMis   = 1'b0;
        case (MemCtrl_m)
            3'b000, 3'b100: sizeMis = 1'b0;
            3'b001, 3'b101: sizeMis = off[0];
            3'b010:         sizeMis = |off;
            default:        ctrlLegal = 1'b0;
        endcase
    end

    // An illegal width code is folded into misalignment so it also bypasses the cache.
    assign misalign   = memOp & (~ctrlLegal | sizeMis);
    assign alignedMem = memOp & ~misalign;

    assign dc_we   = isStore;
    assign dc_addr = {ALUResult_m[DATA_WIDTH-1:2], 2'b00};

    always_comb begin
        dc_wdata = WriteData_m;
        dc_wstrb = 4'b0000;
        case (MemCtrl_m[1:0])
            2'b00: begin
                dc_wdata = {4{WriteData_m[7:0]}};
                dc_wstrb = 4'b0001 << off;
            end
            2'b01: begin
                dc_wdata = {2{WriteData_m[15:0]}};
                dc_wstrb = 4'b0011 << off;
            end
            default: dc_wstrb = 4'b1111;
        endcase
        if (!isStore) begin
            dc_wstrb = 4'b0000;
        end
    end

    always_comb begin
        loadByte = dc_rdata[{off, 3'b000} +: 8];
        loadHalf = dc_rdata[{off[1], 4'b0000} +: 16];
        case (MemCtrl_m)
            3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
            3'b100:  loadData = {24'b0, loadByte};
            3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
            3'b101:  loadData = {16'b0, loadHalf};
            3'b010:  loadData = dc_rdata;
            default: loadData = '0;
        endcase
        case (ResultSrc_m)
            2'b00:   result = ALUResult_m;
            2'b01:   result = loadData;
            2'b10:   result = PCPlus4_m;
            default: result = '0;
        endcase
    end

    // Retirement and next state; upstream holds the M inputs while stalled.
    always_comb begin
        retire  = 1'b0;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_m && !alignedMem) begin
                    retire = 1'b1;
                end else if (alignedMem) begin
                    if (isStore) begin
                        retire  = dc_ready;
                        state_d = dc_ready ? IDLE : REQ;
                    end else begin
                        state_d = dc_ready ? WAIT : REQ;
                    end
                end
            end
            REQ: begin
                if (!alignedMem) begin
                    state_d = IDLE;
                end else if (dc_ready) begin
                    retire  = isStore;
                    state_d = isStore ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (dc_rvalid) begin
                    retire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        retire = retire & rst_n;
    end

    assign dc_req  = rst_n & alignedMem & (state_q != WAIT);
    assign stall_m = rst_n & alignedMem & ~retire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            result_q   <= '0;
            rd_q       <= '0;
            regWrite_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= retire;
            if (retire) begin
                result_q   <= result;
                rd_q       <= Rd_m;
                regWrite_q <= RegWrite_m & ~misalign;
                misalign_q <= misalign;
            end
        end
    end

    assign valid_w    = valid_q;
    assign Result_w   = result_q;
    assign Rd_w       = rd_q;
    assign RegWrite_w = regWrite_q;
    assign misalign_w = misalign_q;

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Memory stage of the pipelined-plus-cache core: consumes the EX/MEM pipeline register outputs, issues load/store requests to the data cache over a valid/ready handshake, and aligns store data and byte strobes. It sign- or zero-extends load data, selects the writeback result, and registers it into the MEM/WB register. It raises `stall_m` while a memory access is outstanding so the EX/MEM register and all earlier stages hold.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data/address width (only 32 supported)
- `REG_ADDR_WIDTH`, 5, destination register index width
- `SRC_WIDTH`, 2, ResultSrc width
- `MEM_CTRL_WIDTH`, 3, MemCtrl width (RISC-V funct3)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `valid_m`  in  1  instruction in M is valid
- `PCPlus4_m`, `ALUResult_m`, `WriteData_m`  in  32 each  from EX/MEM; ALUResult_m is the byte address for memory ops
- `Rd_m`  in  5  destination register
- `RegWrite_m`  in  1  register write enable
- `ResultSrc_m`  in  2  00 ALU, 01 load data, 10 PC+4, 11 reserved (result 0)
- `MemWrite_m`  in  1  store
- `MemCtrl_m`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal
- `dc_req`  out  1  cache request valid
- `dc_we`  out  1  1 = store
- `dc_addr`  out  32  word-aligned address ({ALUResult_m[31:2], 2'b00})
- `dc_wdata`  out  32  lane-replicated store data
- `dc_wstrb`  out  4  byte strobes (0000 for loads)
- `dc_ready`  in  1  cache accepts request this cycle
- `dc_rvalid`  in  1  load data valid
- `dc_rdata`  in  32  load word
- `stall_m`  out  1  M cannot retire this cycle; upstream holds
- `valid_w`, `Result_w` (32), `Rd_w` (5), `RegWrite_w`, `misalign_w`  out  MEM/WB register

## Operation
- Load means valid_m & ResultSrc_m==01 & !MemWrite_m. Store means valid_m & MemWrite_m. Any other valid instruction is a non-memory op.
- Misalignment rules:
  - H/HU is misaligned when addr[0]=1.
  - W is misaligned when addr[1:0]!=0.
  - An illegal MemCtrl on a memory op counts as misaligned.
  - A misaligned op issues no dc_req, retires in the same cycle with misalign_w=1 and RegWrite_w forced to 0, and never stalls.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: for an aligned memory op, assert dc_req combinationally.
    - Store with dc_ready=1: retires this cycle and stays in IDLE.
    - Store with dc_ready=0: move to REQ.
    - Load with dc_ready=1: move to WAIT.
    - Load with dc_ready=0: move to REQ.
  - REQ: dc_req held at 1 with dc_we/addr/wdata/wstrb stable until dc_ready. On dc_ready, a store retires and returns to IDLE; a load moves to WAIT.
  - WAIT: dc_req=0. On dc_rvalid, the load retires and the FSM returns to IDLE.
- dc_rvalid is valid only in WAIT. In IDLE or REQ it is ignored, and the same-cycle rvalid of an accepted request in IDLE is not legal from the cache.
- stall_m = aligned memory op present & !(retires this cycle).
- Store lanes, with off = addr[1:0]:
  - B: wdata={4{WriteData_m[7:0]}}, wstrb=0001<<off
  - H: wdata={2{WriteData_m[15:0]}}, wstrb=0011<<off
  - W: wdata=WriteData_m, wstrb=1111
- Load extract: the byte is dc_rdata[8*off+:8] and the halfword is dc_rdata[16*off[1]+:16]. B/H sign-extend, BU/HU zero-extend, W passes through.
- MEM/WB update, every clock:
  - If an instruction retires: valid_w=1, and Result_w, Rd_w, RegWrite_w, misalign_w are loaded.
  - Otherwise valid_w=0 and the other W outputs keep their values.
  - Non-memory ops and invalid slots never stall. A valid non-memory op retires in the same cycle.

## Timing
- Reset (rst_n=0 at an edge):
  - FSM goes to IDLE.
  - valid_w, Result_w, Rd_w, RegWrite_w, misalign_w all become 0.
- While rst_n=0, dc_req=0 and stall_m=0.
- Reset mid-access (REQ or WAIT) abandons the access, and a later dc_rvalid is ignored. The cache shares rst_n.
- Latency:
  - Non-memory or misaligned op: 0 extra cycles.
  - Store: 0 extra cycles if dc_ready=1 on the first cycle, otherwise one extra cycle per dc_ready=0 cycle.
  - Load: at least 1 extra cycle (accept, then rvalid one or more cycles later).
- Back-to-back memory ops: the next op's dc_req can assert in the cycle after the previous op retires. There is no dead cycle.
- stall_m is combinational from state, valid_m, ResultSrc_m/MemWrite_m, dc_ready and dc_rvalid. It has no path from dc_rdata.

## Test plan
- Sequence: reset, then one cycle of ALU op (ALUResult_m=0x1234, ResultSrc=00, Rd=5) → next cycle valid_w=1, Result_w=0x1234, Rd_w=5, stall_m=0 throughout.
- SB with addr 0x1003, WriteData 0xAABBCCDD, dc_ready=1 → dc_addr=0x1000, wdata=0xDDDDDDDD, wstrb=1000, no stall.
- LB with addr 0x2002, dc_ready=1, dc_rvalid 3 cycles later with rdata=0x00800000 → stall_m high for 3 cycles, then Result_w=0xFFFFFF80. Repeat with LBU → Result_w=0x00000080.
- SW with dc_ready low for 2 cycles → dc_req held for 3 cycles with stable addr/data, stall_m high for 2 cycles, single retire.
- LW at 0x2001 → no dc_req, misalign_w=1, RegWrite_w=0, no stall.
- Load in WAIT, rst_n low for 1 cycle, then dc_rvalid → valid_w=0, FSM IDLE, no retire.
